// File: rtl/rll_key_loader_if.sv
// Key-loader control/status bundle shared by the key source (master) and the loader (slave).
interface rll_key_loader_if #(
    parameter int KEY_W = 32
);
    logic             start;
    logic             clear;
    logic             sdi;
    logic             sdi_valid;
    logic             busy;
    logic             done;
    logic             lock_err;
    logic             key_valid;
    logic [KEY_W-1:0] key_out;

    modport master (
        output start, clear, sdi, sdi_valid,
        input  busy, done, lock_err, key_valid, key_out
    );

    modport slave (
        input  start, clear, sdi, sdi_valid,
        output busy, done, lock_err, key_valid, key_out
    );
endinterface

// File: rtl/rll_key_loader.sv
// Serial key loader for RLL-locked netlists: shifts in KEY_W bits MSB first plus an even-parity bit,
// then commits the key to a held parallel register. Optional macro RLL_KEY_ZEROIZE_EN wipes the key on parity failure.
module rll_key_loader #(
    parameter int KEY_W = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    rll_key_loader_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_PARITY = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [KEY_W-1:0]   r_shadow;
    logic [KEY_W-1:0]   w_shadow_nxt;
    logic [KEY_W-1:0]   r_key;
    logic [KEY_W-1:0]   w_key_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_key_valid;
    logic               w_key_valid_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_lock_err;
    logic               w_lock_err_nxt;
    logic               r_busy;
    logic               w_par_err;

    // Nonzero when the key bits plus the trailing parity bit have odd weight.
    function automatic logic even_par_err(input logic [KEY_W-1:0] data, input logic par_bit);
        return (^data) ^ par_bit;
    endfunction

    assign w_par_err = even_par_err(r_shadow, bus.sdi);

    // Next-state and datapath update; clear overrides every state-specific action.
    always_comb begin
        w_state_nxt     = r_state;
        w_shadow_nxt    = r_shadow;
        w_key_nxt       = r_key;
        w_cnt_nxt       = r_cnt;
        w_key_valid_nxt = r_key_valid;
        w_lock_err_nxt  = r_lock_err;
        w_done_nxt      = 1'b0;

        if (bus.clear) begin
            w_state_nxt     = ST_IDLE;
            w_shadow_nxt    = {KEY_W{1'b0}};
            w_key_nxt       = {KEY_W{1'b0}};
            w_cnt_nxt       = {CNT_W{1'b0}};
            w_key_valid_nxt = 1'b0;
            w_lock_err_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        w_state_nxt     = ST_SHIFT;
                        w_cnt_nxt       = {CNT_W{1'b0}};
                        w_shadow_nxt    = {KEY_W{1'b0}};
                        w_key_valid_nxt = 1'b0;
                        w_lock_err_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (bus.sdi_valid) begin
                        w_shadow_nxt = {r_shadow[KEY_W-2:0], bus.sdi};
                        w_cnt_nxt    = r_cnt + CNT_ONE;
                        if (r_cnt == LAST_BIT) begin
                            w_state_nxt = ST_PARITY;
                        end else begin
                            w_state_nxt = ST_SHIFT;
                        end
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end
                ST_PARITY: begin
                    if (bus.sdi_valid) begin
                        w_state_nxt = ST_IDLE;
                        if (!w_par_err) begin
                            w_key_nxt       = r_shadow;
                            w_key_valid_nxt = 1'b1;
                            w_done_nxt      = 1'b1;
                        end else begin
                            w_lock_err_nxt = 1'b1;
`ifdef RLL_KEY_ZEROIZE_EN
                            w_key_nxt    = {KEY_W{1'b0}};
                            w_shadow_nxt = {KEY_W{1'b0}};
`else
                            w_key_nxt    = r_key;
`endif
                        end
                    end else begin
                        w_state_nxt = ST_PARITY;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and status registers; busy tracks the registered state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow    <= {KEY_W{1'b0}};
            r_key       <= {KEY_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_key_valid <= 1'b0;
            r_lock_err  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_shadow    <= w_shadow_nxt;
            r_key       <= w_key_nxt;
            r_cnt       <= w_cnt_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_lock_err  <= w_lock_err_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.lock_err  = r_lock_err;
    assign bus.key_valid = r_key_valid;
    assign bus.key_out   = r_key;

endmodule
